mips_regfile_write_arbiter: RTL and testbench



---
 rtl/mips_regfile_write_arbiter.sv | 120 ++++++++++++
 tb/tb_mips_regfile_write_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_write_arbiter.sv
// Two-port writeback arbiter for the MIPS register file: port 0 priority, port 1 starvation guard.
// Optional REGFILE_ARB_STATS_EN adds saturating ConflictCount / ForceCount outputs.
module mips_regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Req0Valid,
    input  logic [ADDR_W-1:0] Req0Addr,
    input  logic [DATA_W-1:0] Req0Data,
    output logic              Req0Ready,
    input  logic              Req1Valid,
    input  logic [ADDR_W-1:0] Req1Addr,
    input  logic [DATA_W-1:0] Req1Data,
    output logic              Req1Ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteAddress,
    output logic [DATA_W-1:0] DataIn,
    output logic              Starving
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [15:0]       ConflictCount,
    output logic [15:0]       ForceCount
`endif
);

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              starving;
    logic              ready0, ready1;
    logic              hs0, hs1;

    assign starving = (wait_cnt_q == MaxWait);
    assign ready0   = !starving;
    assign ready1   = starving || !Req0Valid;
    assign hs0      = Req0Valid && ready0;
    assign hs1      = Req1Valid && ready1;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!Req1Valid || hs1) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q < MaxWait) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // hs0 and hs1 are mutually exclusive by construction of the readies.
    always_comb begin
        regwrite_d = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        if (hs1) begin
            regwrite_d = (Req1Addr != '0);
            addr_d     = Req1Addr;
            data_d     = Req1Data;
        end else if (hs0) begin
            regwrite_d = (Req0Addr != '0);
            addr_d     = Req0Addr;
            data_d     = Req0Data;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt_q <= 8'd0;
            regwrite_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            regwrite_q <= regwrite_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign Req0Ready    = ready0;
    assign Req1Ready    = ready1;
    assign Starving     = starving;
    assign RegWrite     = regwrite_q;
    assign WriteAddress = addr_q;
    assign DataIn       = data_q;

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] conflict_q, conflict_d;
    logic [15:0] force_q, force_d;

    always_comb begin
        conflict_d = conflict_q;
        force_d    = force_q;
        if (Req0Valid && Req1Valid && conflict_q != 16'hFFFF) begin
            conflict_d = conflict_q + 16'd1;
        end
        if (starving && Req1Valid && force_q != 16'hFFFF) begin
            force_d = force_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            conflict_q <= 16'd0;
            force_q    <= 16'd0;
        end else begin
            conflict_q <= conflict_d;
            force_q    <= force_d;
        end
    end

    assign ConflictCount = conflict_q;
    assign ForceCount    = force_q;
`endif

endmodule

// File: tb/tb_mips_regfile_write_arbiter.sv
// Scoreboard bench for mips_regfile_write_arbiter (MAX_WAIT=4).
// Driver pushes expected register writes; a negedge monitor pops and compares.
module tb_mips_regfile_write_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Req0Valid, Req1Valid;
    logic [4:0]  Req0Addr, Req1Addr;
    logic [31:0] Req0Data, Req1Data;
    logic        Req0Ready, Req1Ready;
    logic        RegWrite;
    logic [4:0]  WriteAddress;
    logic [31:0] DataIn;
    logic        Starving;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] ConflictCount, ForceCount;
`endif

    always #5 CLK = ~CLK;

    mips_regfile_write_arbiter #(
        .DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .Req0Valid(Req0Valid), .Req0Addr(Req0Addr),
        .Req0Data(Req0Data), .Req0Ready(Req0Ready),
        .Req1Valid(Req1Valid), .Req1Addr(Req1Addr),
        .Req1Data(Req1Data), .Req1Ready(Req1Ready),
        .RegWrite(RegWrite), .WriteAddress(WriteAddress),
        .DataIn(DataIn), .Starving(Starving)
`ifdef REGFILE_ARB_STATS_EN
        , .ConflictCount(ConflictCount), .ForceCount(ForceCount)
`endif
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // One cycle of stimulus; expected readies are hand-computed by the caller.
    task automatic cyc(string n,
                       logic v0, logic [4:0] a0, logic [31:0] d0,
                       logic v1, logic [4:0] a1, logic [31:0] d1,
                       logic r0, logic r1, logic st);
        Req0Valid = v0; Req0Addr = a0; Req0Data = d0;
        Req1Valid = v1; Req1Addr = a1; Req1Data = d1;
        @(negedge CLK);
        chk({n, " Req0Ready"}, 64'(Req0Ready), 64'(r0));
        chk({n, " Req1Ready"}, 64'(Req1Ready), 64'(r1));
        chk({n, " Starving"}, 64'(Starving), 64'(st));
        if (v0 && r0 && a0 != 5'd0) exp_q.push_back('{a: a0, d: d0});
        if (v1 && r1 && a1 != 5'd0) exp_q.push_back('{a: a1, d: d1});
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            cyc("idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        end
    endtask

    // Monitor: every visible register write must match the oldest expectation.
    always @(negedge CLK) begin
        wr_t e;
        if (!RESET && RegWrite) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                         WriteAddress, DataIn);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(WriteAddress), 64'(e.a));
                chk("wr_data", 64'(DataIn), 64'(e.d));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        Req0Valid = 1'b0; Req0Addr = '0; Req0Data = '0;
        Req1Valid = 1'b0; Req1Addr = '0; Req1Data = '0;
        #1;
        chk("rst RegWrite", 64'(RegWrite), 64'd0);
        chk("rst WriteAddress", 64'(WriteAddress), 64'd0);
        chk("rst DataIn", 64'(DataIn), 64'd0);
        chk("rst Starving", 64'(Starving), 64'd0);
        #11 RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Single port-0 write; Req1Ready low because port 0 is valid.
        cyc("single", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Simultaneous: port 0 wins, port 1 follows with no bubble.
        cyc("sim0", 1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b0);
        cyc("sim1", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Starvation: four blocked cycles, then a forced port-1 grant.
        for (int i = 0; i < 4; i++) begin
            cyc("starve_blk", 1'b1, 5'(10 + i), 32'(32'h100 + i),
                1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 1'b0);
        end
        cyc("starve_force", 1'b1, 5'd14, 32'h104, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b1);
        cyc("starve_resume", 1'b1, 5'd14, 32'h104, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Register 0: handshake happens, no RegWrite, address/data still update.
        cyc("reg0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b1, 1'b1, 1'b0);
        Req1Valid = 1'b0;
        @(negedge CLK);
        chk("reg0 WriteAddress", 64'(WriteAddress), 64'd0);
        chk("reg0 DataIn", 64'(DataIn), 64'h1234);
        @(posedge CLK);
        #1;
        idle(1);

        // Reset mid-operation with the counter at 3 and a write pending.
        for (int i = 0; i < 3; i++) begin
            cyc("pre_rst", 1'b1, 5'(20 + i), 32'(32'hA0 + i),
                1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0);
        end
        RESET = 1'b1;
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        #1;
        chk("midrst RegWrite", 64'(RegWrite), 64'd0);
        chk("midrst WriteAddress", 64'(WriteAddress), 64'd0);
        chk("midrst DataIn", 64'(DataIn), 64'd0);
        chk("midrst Starving", 64'(Starving), 64'd0);
        exp_q.delete();
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        cyc("post_rst0", 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0);
        cyc("post_rst1", 1'b1, 5'd1, 32'h12, 1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 1'b0);
        cyc("post_rst_p1", 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h22, 1'b1, 1'b1, 1'b0);
        idle(2);

`ifdef REGFILE_ARB_STATS_EN
        RESET = 1'b1;
        #2 RESET = 1'b0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                cyc("stats_force", 1'b1, 5'd4, 32'(i), 1'b1, 5'd9, 32'h99,
                    1'b0, 1'b1, 1'b1);
            end else begin
                cyc("stats_blk", 1'b1, 5'd4, 32'(i), 1'b1, 5'd9, 32'h99,
                    1'b1, 1'b0, 1'b0);
            end
        end
        chk("ConflictCount", 64'(ConflictCount), 64'd10);
        chk("ForceCount", 64'(ForceCount), 64'd2);
        idle(2);
`endif

        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
